output_mems: RTL and testbench

OUTPUT_MEMS -- requirements
Module: output_mems

---
 rtl/output_mems_pkg.sv | 18 +
 rtl/output_mems_memory.sv | 29 ++
 rtl/output_mems.sv | 106 ++++++++++
 tb/tb_output_mems.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_mems_pkg.sv
// Shared types and width helpers for the result/operand buffer blocks.
package output_mems_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    SEND     = 2'd2
  } state_t;

  function automatic int k_bits_f(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int addr_bits_f(input int r, input int c);
    return (r * c > 1) ? $clog2(r * c) : 1;
  endfunction

endpackage

// File: rtl/output_mems_memory.sv
// Simple dual-port buffer: one write port, one registered read port (1-cycle latency).
module output_mems_memory #(
  parameter int WIDTH = 52,
  parameter int SIZE  = 72,
  localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < SIZE)) mem[wr_addr] <= wr_data;
  end

  // Read register is reset so the streamed word is clean after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rd_data <= '0;
    else if (32'(rd_addr) < SIZE)    rd_data <= mem[rd_addr];
    else                             rd_data <= '0;
  end

endmodule

// File: rtl/output_mems.sv
// Result buffer: collects compute results, then streams the valid window out over AXI-Stream.
// IDLE: accept writes | PREFETCH: read word 0 | SEND: stream words until TLAST handshake
module output_mems
  import output_mems_pkg::*;
#(
  parameter int OUTW = 52,
  parameter int R    = 9,
  parameter int C    = 8,
  parameter int MAXK = 4,
  localparam int K_BITS      = k_bits_f(MAXK),
  localparam int Y_ADDR_BITS = addr_bits_f(R, C)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [K_BITS-1:0]      K,
  input  logic                   Y_wr_en,
  input  logic [Y_ADDR_BITS-1:0] Y_wr_addr,
  input  logic signed [OUTW-1:0] Y_wr_data,
  input  logic                   compute_finished,
  output logic                   output_ready,
  output logic signed [OUTW-1:0] AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY,
  output logic                   AXIS_TLAST
);

  localparam int CNT_W = Y_ADDR_BITS + 1;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         idx, idx_nxt;
  logic [K_BITS-1:0]        k_lat, k_lat_nxt;
  logic [CNT_W-1:0]         n_words;
  logic                     k_ok, hs, last;
  logic [Y_ADDR_BITS-1:0]   rd_addr;
  logic [OUTW-1:0]          rd_data;

  assign k_ok    = (K != '0) && (32'(K) <= 32'(R)) && (32'(K) <= 32'(C));
  assign n_words = CNT_W'((R + 1 - int'(k_lat)) * (C + 1 - int'(k_lat)));
  assign last    = (idx == n_words - 1'b1);
  assign hs      = (state == SEND) && AXIS_TREADY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      k_lat <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      k_lat <= k_lat_nxt;
    end
  end

  // On a handshake the read address jumps to the next index so the word is ready with no bubble.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    k_lat_nxt = k_lat;
    rd_addr   = Y_ADDR_BITS'(idx);
    case (state)
      IDLE: begin
        rd_addr = '0;
        if (compute_finished && k_ok) begin
          k_lat_nxt = K;
          idx_nxt   = '0;
          state_nxt = PREFETCH;
        end
      end
      PREFETCH: begin
        rd_addr   = '0;
        state_nxt = SEND;
      end
      SEND: begin
        if (hs) begin
          if (last) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
            rd_addr = Y_ADDR_BITS'(idx + 1'b1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  output_mems_memory #(
    .WIDTH (OUTW),
    .SIZE  (R * C)
  ) u_mem (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (Y_wr_en && (state == IDLE)),
    .wr_addr (Y_wr_addr),
    .wr_data (Y_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign output_ready = (state == IDLE);
  assign AXIS_TVALID  = (state == SEND);
  assign AXIS_TLAST   = (state == SEND) && last;
  assign AXIS_TDATA   = (state == SEND) ? rd_data : '0;

endmodule

// File: tb/tb_output_mems.sv
// Directed bench for output_mems with a queue-based reference model checked every cycle.
module tb_output_mems;

  localparam int OUTW = 52;
  localparam int R    = 9;
  localparam int C    = 8;
  localparam int MAXK = 9;
  localparam int KB   = 4;
  localparam int AW   = 7;

  logic                   clk = 0;
  logic                   rst = 0;
  logic [KB-1:0]          k_in = '0;
  logic                   wr_en = 0;
  logic [AW-1:0]          wr_addr = '0;
  logic signed [OUTW-1:0] wr_data = '0;
  logic                   fin = 0;
  logic                   tready = 0;
  logic                   output_ready, tvalid, tlast;
  logic signed [OUTW-1:0] tdata;

  always #5 clk = ~clk;

  output_mems #(.OUTW(OUTW), .R(R), .C(C), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset            (rst),
    .K                (k_in),
    .Y_wr_en          (wr_en),
    .Y_wr_addr        (wr_addr),
    .Y_wr_data        (wr_data),
    .compute_finished (fin),
    .output_ready     (output_ready),
    .AXIS_TDATA       (tdata),
    .AXIS_TVALID      (tvalid),
    .AXIS_TREADY      (tready),
    .AXIS_TLAST       (tlast)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: buffer contents plus the queue of words still owed to the stream.
  logic signed [OUTW-1:0] mdl_mem [R*C];
  logic signed [OUTW-1:0] exp_q [$];
  bit exp_active = 0;
  int exp_delay  = 0;
  int kk, nn;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_active = 0;
      exp_delay  = 0;
      exp_q.delete();
    end else if (exp_active) begin
      if (exp_delay > 0) exp_delay--;
      else if (tready) begin
        exp_q.delete(0);
        if (exp_q.size() == 0) exp_active = 0;
      end
    end else begin
      if (wr_en) mdl_mem[wr_addr] = wr_data;
      kk = int'(k_in);
      if (fin && kk >= 1 && kk <= R && kk <= C) begin
        nn = (R - kk + 1) * (C - kk + 1);
        for (int i = 0; i < nn; i++) exp_q.push_back(mdl_mem[i]);
        exp_active = 1;
        exp_delay  = 1;
      end
    end
  end

  bit etv;
  always @(negedge clk) begin
    etv = exp_active && (exp_delay == 0);
    chk("tvalid", tvalid, etv);
    chk("output_ready", output_ready, !exp_active);
    if (etv) begin
      chk("tdata", tdata, exp_q[0]);
      chk("tlast", tlast, exp_q.size() == 1);
    end
  end

  // Log of accepted beats for the per-job literal checks.
  logic signed [OUTW-1:0] got [$];
  bit got_last [$];
  int hs_cyc [$];
  int pulse_cyc = 0;
  int tv_cyc = 0;
  bit seen_tv = 0;

  always @(negedge clk) begin
    if (fin) pulse_cyc = cyc;
    if (tvalid && !seen_tv) begin
      seen_tv = 1;
      tv_cyc  = cyc;
    end
    if (tvalid && tready) begin
      got.push_back(tdata);
      got_last.push_back(tlast);
      hs_cyc.push_back(cyc);
    end
  end

  bit pat [4] = '{1, 0, 0, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got.delete();
    got_last.delete();
    hs_cyc.delete();
    seen_tv = 0;
  endtask

  task automatic write_block(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1;
      wr_addr = AW'(i);
      wr_data = OUTW'(base + i);
      tick();
    end
    wr_en = 0;
  endtask

  function automatic int count_last();
    int s = 0;
    foreach (got_last[i]) s += int'(got_last[i]);
    return s;
  endfunction

  task automatic run_job(input int k, input bit stall, input bit same_wr, input int same_data,
                         input bit send_wr);
    bit done = 0;
    clear_log();
    k_in   = KB'(k);
    fin    = 1;
    tready = 1;
    if (same_wr) begin
      wr_en   = 1;
      wr_addr = '0;
      wr_data = OUTW'(same_data);
    end
    tick();
    fin   = 0;
    wr_en = 0;
    for (int i = 0; i < 2000; i++) begin
      tready = stall ? pat[i % 4] : 1'b1;
      if (send_wr && i == 5) begin
        wr_en   = 1;
        wr_addr = '0;
        wr_data = -5;
      end else begin
        wr_en = 0;
      end
      tick();
      if (!exp_active) begin
        done = 1;
        break;
      end
    end
    wr_en  = 0;
    tready = 0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: got running expected finished (cycle %0d)", cyc);
    end
    @(negedge clk);
    chk("ready_after_last", output_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_invalid(input int k);
    clear_log();
    k_in = KB'(k);
    fin  = 1;
    tick();
    fin = 0;
    repeat (4) tick();
    chk("bad_k_ready", output_ready, 1);
    chk("bad_k_no_tvalid", seen_tv, 0);
  endtask

  initial begin
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_ready", output_ready, 1);
    @(posedge clk);
    #1;
    rst = 0;
    tick();

    // K=4: 30 words 100..129
    write_block(30, 100);
    run_job(4, 0, 0, 0, 0);
    chk("k4_count", got.size(), 30);
    chk("k4_first_tvalid_latency", tv_cyc - pulse_cyc, 2);
    chk("k4_tlast_count", count_last(), 1);
    if (got.size() == 30) begin
      chk("k4_first_word", got[0], 100);
      chk("k4_last_word", got[29], 129);
      chk("k4_tlast_on_last", got_last[29], 1);
    end

    // K=1: 72 words back to back
    write_block(72, 1000);
    run_job(1, 0, 0, 0, 0);
    chk("k1_count", got.size(), 72);
    if (got.size() == 72) begin
      chk("k1_no_bubbles", hs_cyc[71] - hs_cyc[0], 71);
      chk("k1_last_word", got[71], 1071);
      chk("k1_tlast_on_last", got_last[71], 1);
    end

    // K=4 with stalling ready and a write attempt mid-stream
    run_job(4, 1, 0, 0, 1);
    chk("stall_count", got.size(), 30);
    chk("stall_tlast_count", count_last(), 1);
    if (got.size() == 30)
      for (int i = 0; i < 30; i++) chk("stall_order", got[i], 1000 + i);

    run_job(4, 0, 0, 0, 0);
    chk("send_write_ignored", (got.size() > 0) ? got[0] : 64'sd0, 1000);

    // Write and finish in the same cycle
    run_job(4, 0, 1, 77, 0);
    chk("same_cycle_write", (got.size() > 0) ? got[0] : 64'sd0, 77);
    chk("same_cycle_next", (got.size() > 1) ? got[1] : 64'sd0, 1001);

    pulse_invalid(0);
    pulse_invalid(9);

    // Reset after the 10th handshake
    write_block(30, 200);
    clear_log();
    k_in   = 4'd4;
    fin    = 1;
    tready = 1;
    tick();
    fin = 0;
    for (int i = 0; i < 200; i++) begin
      if (got.size() >= 10) break;
      tick();
    end
    rst = 1;
    @(negedge clk);
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_ready", output_ready, 1);
    chk("midrst_tdata", tdata, 0);
    chk("midrst_hs_count", got.size(), 10);
    @(posedge clk);
    #1;
    rst = 0;
    tready = 0;
    tick();
    write_block(30, 300);
    run_job(4, 0, 0, 0, 0);
    chk("post_rst_count", got.size(), 30);
    chk("post_rst_first", (got.size() > 0) ? got[0] : 64'sd0, 300);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
